// File: rtl/sort_pkg.sv
// Shared definitions for the tile-sort scheduler: FSM states, class codes and queue entry layout.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DUE = 2'd1,
    ST_PULSE    = 2'd2,
    ST_HOLD     = 2'd3
  } sort_state_t;

  localparam logic CLS_GOOD   = 1'b0;
  localparam logic CLS_DEFECT = 1'b1;

  localparam int unsigned SORT_TS_W = 32;

  // Queue entry: class bit above the due timestamp.
  typedef struct packed {
    logic                 cls;
    logic [SORT_TS_W-1:0] due;
  } sort_entry_t;

endpackage

// File: rtl/sort_fifo.sv
// Synchronous FIFO holding scheduled tile results; push while full is accepted only alongside a pop.
module sort_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned W      = 33
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [W-1:0]      wr_data_i,
  output logic [W-1:0]      rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full_o    = (count_o == (ADDR_W+1)'(DEPTH));
  assign empty_o   = (count_o == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count_o <= count_o + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sort_scheduler.sv
// Tile-sort scheduler: queues classifications and fires spaced left/right servo pulses when each tile is due.
// Optional statistics counters enabled by defining SORT_SCHEDULER_STATS_EN.
module sort_scheduler
  import sort_pkg::*;
#(
  parameter int unsigned     TRAVEL_CYCLES = 27_000_000,
  parameter int unsigned     HOLD_CYCLES   = 13_500_000,
  parameter int unsigned     PULSE_CYCLES  = 4,
  parameter int unsigned     LATE_TOL      = 16,
  parameter int unsigned     DEPTH         = 8,
  parameter int unsigned     ADDR_W        = 3,
  parameter int unsigned     TS_W          = SORT_TS_W,
  parameter logic [TS_W-1:0] TS_RESET      = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              result_valid_i,
  input  logic              result_defect_i,
  output logic              left_o,
  output logic              right_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   pending_o,
  output logic              overflow_o,
  output logic              late_o
`ifdef SORT_SCHEDULER_STATS_EN
  ,
  output logic [15:0]       defect_cnt_o,
  output logic [15:0]       good_cnt_o,
  output logic [15:0]       drop_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  sort_state_t     state;
  logic [TS_W-1:0] now_q;
  logic [TS_W-1:0] lag;
  logic [TS_W:0]   head;
  logic [TS_W:0]   wr_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic            head_due;
  logic            issue;
  logic            drop;
  logic [PW-1:0]   pulse_cnt;
  logic [HW-1:0]   hold_cnt;

  // Due is stored in terms of the now value seen at the issuing edge, one edge after TRAVEL_CYCLES elapse.
  assign wr_entry = {result_defect_i, now_q + TS_W'(TRAVEL_CYCLES + 1)};
  assign lag      = now_q - head[TS_W-1:0];
  assign head_due = !fifo_empty && !lag[TS_W-1];
  assign issue    = head_due && ((state == ST_WAIT_DUE) || (state == ST_HOLD && hold_cnt == '0));
  assign drop     = result_valid_i && fifo_full && !issue;
  assign busy_o   = !fifo_empty || (state != ST_IDLE);

  sort_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (TS_W + 1)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (result_valid_i),
    .pop_i     (issue),
    .wr_data_i (wr_entry),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (pending_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      now_q      <= TS_RESET;
      pulse_cnt  <= '0;
      hold_cnt   <= '0;
      left_o     <= 1'b0;
      right_o    <= 1'b0;
      late_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      now_q  <= now_q + TS_W'(1);
      late_o <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
      if (drop) overflow_o <= 1'b1;
      // A head already due when HOLD expires is issued on that edge, skipping IDLE.
      if (issue) begin
        state     <= ST_PULSE;
        left_o    <= (head[TS_W] == CLS_DEFECT);
        right_o   <= (head[TS_W] == CLS_GOOD);
        pulse_cnt <= PW'(PULSE_CYCLES - 1);
        hold_cnt  <= HW'(HOLD_CYCLES - 1);
        late_o    <= (lag > TS_W'(LATE_TOL));
      end else begin
        case (state)
          ST_IDLE:     if (!fifo_empty) state <= ST_WAIT_DUE;
          ST_WAIT_DUE: state <= ST_WAIT_DUE;
          ST_PULSE: begin
            if (pulse_cnt == '0) begin
              left_o  <= 1'b0;
              right_o <= 1'b0;
              state   <= ST_HOLD;
            end else begin
              pulse_cnt <= pulse_cnt - PW'(1);
            end
          end
          ST_HOLD:     if (hold_cnt == '0) state <= ST_IDLE;
          default:     state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SORT_SCHEDULER_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      defect_cnt_o <= '0;
      good_cnt_o   <= '0;
      drop_cnt_o   <= '0;
    end else begin
      if (issue && head[TS_W] == CLS_DEFECT && defect_cnt_o != '1) defect_cnt_o <= defect_cnt_o + 16'd1;
      if (issue && head[TS_W] == CLS_GOOD && good_cnt_o != '1)     good_cnt_o   <= good_cnt_o + 16'd1;
      if (drop && drop_cnt_o != '1)                                drop_cnt_o   <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/sort_scheduler.md
Name: sort_scheduler

Overview:
- Sits directly upstream of the servo controller on the tile-sorting conveyor.
- Accepts one classification result per tile from the defect detector and holds it in a small queue with a timestamp.
- When the tile reaches the diverter, TRAVEL_CYCLES after classification, it issues a rising-edge pulse on left_o (defect) or right_o (good).
- Enforces a minimum spacing of HOLD_CYCLES between actuations so the servo can return to centre.

Parameters:
- TRAVEL_CYCLES, 27_000_000: conveyor delay from classification to diverter (1 s at 27 MHz); must be >= 4.
- HOLD_CYCLES, 13_500_000: minimum cycles from one pulse start to the next pulse start; covers servo deflect and return.
- PULSE_CYCLES, 4: width of the left_o/right_o pulse; must be >= 2 for the servo's two-flop edge capture.
- LATE_TOL, 16: issue lag, in cycles past due, above which the actuation counts as late.
- DEPTH, 8: queue entries; must be a power of two.
- ADDR_W, 3: log2(DEPTH).
- TS_W, 32: timestamp width.

Ports:
- clk_i  in  1  system clock (27 MHz)
- rst_i  in  1  reset, synchronous, active-high
- result_valid_i  in  1  one-cycle strobe; a classification result is present
- result_defect_i  in  1  1 = defective (divert left), 0 = good (divert right); sampled with result_valid_i
- left_o  out  1  pulse to the servo left input
- right_o  out  1  pulse to the servo right input
- busy_o  out  1  queue non-empty or FSM not IDLE
- pending_o  out  ADDR_W+1  number of queued entries
- overflow_o  out  1  sticky: a result was dropped because the queue was full
- late_o  out  1  one-cycle strobe: an actuation issued more than LATE_TOL cycles past its due time

Behaviour:
- Reset: one clock and one reset only; rst_i is synchronous and active-high.
  - Clears queue, timestamp counter, FSM (to IDLE) and all timers.
  - All outputs are 0 from the first edge with rst_i high.
  - Reset mid-pulse or mid-hold drops left_o/right_o immediately; queued results are discarded.
- Timestamp: free-running TS_W counter "now", incremented every cycle, wraps naturally.
- Due test: (now - due) evaluated as a signed TS_W difference, due when >= 0. This stays correct across wrap provided TRAVEL_CYCLES < 2^(TS_W-1).
- Enqueue:
  - On result_valid_i, store {result_defect_i, due = now + TRAVEL_CYCLES}, with now sampled at the accepting edge.
  - If the queue is full and no pop occurs that cycle: drop the result and set overflow_o until reset.
  - Simultaneous push and pop when full: both accepted; pending_o unchanged.
- FSM:
  - IDLE: when the queue is non-empty, go to WAIT_DUE.
  - WAIT_DUE: when the head entry is due, go to PULSE. On that same edge:
    - pop the head;
    - assert left_o if class = 1, else right_o;
    - load the pulse counter with PULSE_CYCLES and the hold counter with HOLD_CYCLES;
    - if (now - due) > LATE_TOL, strobe late_o.
  - PULSE: drive exactly one of left_o/right_o high for PULSE_CYCLES cycles, then go to HOLD with both low.
  - HOLD: wait until HOLD_CYCLES cycles have elapsed since pulse start, then go to IDLE.
  - A head that falls due during HOLD is issued on leaving HOLD, so its lag is HOLD-limited; late_o applies if the lag exceeds LATE_TOL.
- Latency (empty queue, idle FSM): left_o/right_o first high exactly TRAVEL_CYCLES+1 cycles after the accepting edge.
- left_o and right_o are never high simultaneously, and both are low between pulses.
- Ordering is strictly FIFO; entries are never reordered, even when a later entry is due first.
- pending_o reflects queue occupancy after each edge (0..DEPTH).

Optional Feature:
- Macro: SORT_SCHEDULER_STATS_EN.
- Defined: adds output ports defect_cnt_o[15:0], good_cnt_o[15:0] and drop_cnt_o[15:0].
  - The first two count issued left and right actuations; drop_cnt_o counts dropped results.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package sort_pkg holds:
  - FSM state encoding (IDLE, WAIT_DUE, PULSE, HOLD);
  - class constants CLS_GOOD = 0, CLS_DEFECT = 1;
  - entry struct/width definition {cls, due[TS_W-1:0]}.
- One sub-module: sort_fifo, a synchronous FIFO with DEPTH x (1+TS_W) entries, push/pop/full/empty/count, same clock and reset. The scheduler FSM and timers live in the top.

Test Plan (sim parameters TRAVEL_CYCLES=100, HOLD_CYCLES=40, PULSE_CYCLES=4, LATE_TOL=16, DEPTH=4):
- Single defect strobe at cycle 10 -> left_o high cycles 111..114, right_o stays 0, late_o stays 0, busy_o low from cycle 151.
- Good results at cycles 10 and 60 -> right_o pulses at 111..114 and 161..164 (spacing 50 >= HOLD), pending_o peaks at 2.
- Defect at cycle 10, good at cycle 15 (due 5 apart, < HOLD) -> left_o at 111..114, right_o at 151..154, late_o strobe at 151 (lag 35 > 16).
- Five results in consecutive cycles 10..14 -> the fifth is dropped, overflow_o = 1 from cycle 15 and stays set, exactly 4 pulses issued in order.
- Assert rst_i for one cycle during the first pulse (cycle 112) -> left_o = 0 at cycle 113, pending_o = 0, no further pulses, overflow_o = 0.
- Preload now to 2^32-50, then strobe a defect -> pulse issued exactly 101 cycles later despite the timestamp wrap.
